// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU wrapper sitting between the ID/EX and EX/MEM latches.
// One operation is accepted per in_valid/in_ready handshake.
// The 5-bit opcode is decoded to one-hot enables.
//
// Single-cycle ops (add/sub/and/or/sll/sra, div-by-zero and unknown opcodes)
// have their outputs registered at the accept edge, so the result appears one
// cycle later. mul and div iterate once per cycle for WIDTH cycles. While they
// run, in_ready is held low and upstream stalls.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   in_valid        upstream presents an operation
//   in_ready        unit can accept an operation (FSM in IDLE)
//   ctrl_ALUopcode  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, 6 mul, 7 div
//   ctrl_shiftamt   shift amount for sll/sra
//   data_operandA   operand A, signed two's complement
//   data_operandB   operand B, signed two's complement
//   out_valid       one-cycle pulse, result fields valid
//   data_result     result (held while out_valid is low)
//   isNotEqual      A != B
//   isLessThan      A < B, signed
//   overflow        signed overflow of this operation
//   exception       mul overflow, div by zero, or INT_MIN / -1
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic               out_valid,
  output logic [WIDTH-1:0]   data_result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               exception
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_SLL = 4;
  localparam int OP_SRA = 5;
  localparam int OP_MUL = 6;
  localparam int OP_DIV = 7;

  localparam logic [WIDTH-1:0]   INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);

  state_t               state;
  logic [SHAMT_W-1:0]   counter;

  // Values captured at the accept edge for the iterative operations.
  logic                 neg_q;
  logic                 special_q;
  logic                 ne_q;
  logic                 lt_q;

  // Shift-add multiplier state.
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;

  // Restoring divider state.
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     divisor;

  // One-hot opcode decode. Opcodes 01000..11111 leave every enable low.
  logic [7:0] op_en;

  always_comb begin
    op_en = '0;
    if (ctrl_ALUopcode[4:3] == 2'b00) begin
      op_en[ctrl_ALUopcode[2:0]] = 1'b1;
    end
  end

  // Arithmetic shared by add/sub and by the compare flags.
  // isLessThan uses the sign of A-B, corrected by the subtract overflow.
  // This keeps it right when the difference wraps around.
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             in_ne;
  logic             in_lt;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic             div_special;

  always_comb begin
    sum         = data_operandA + data_operandB;
    diff        = data_operandA - data_operandB;
    add_ovf     = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                  (sum[WIDTH-1] != data_operandA[WIDTH-1]);
    sub_ovf     = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                  (diff[WIDTH-1] != data_operandA[WIDTH-1]);
    in_ne       = |diff;
    in_lt       = diff[WIDTH-1] ^ sub_ovf;
    sra_res     = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
    abs_a       = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b       = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    b_zero      = (data_operandB == '0);
    div_special = (data_operandA == INT_MIN) && (data_operandB == '1);
  end

  // Result of everything that completes at the accept edge.
  // Division by zero is also resolved here and never enters DIV.
  logic [WIDTH-1:0] fast_result;
  logic             fast_ovf;
  logic             fast_exc;
  logic             fast_ne;
  logic             fast_lt;
  logic             start_iter;

  always_comb begin
    fast_result = '0;
    fast_ovf    = 1'b0;
    fast_exc    = 1'b0;
    fast_ne     = 1'b0;
    fast_lt     = 1'b0;
    start_iter  = op_en[OP_MUL] || (op_en[OP_DIV] && !b_zero);
    if (|op_en) begin
      fast_ne = in_ne;
      fast_lt = in_lt;
    end
    if (op_en[OP_ADD]) begin
      fast_result = sum;
      fast_ovf    = add_ovf;
    end
    if (op_en[OP_SUB]) begin
      fast_result = diff;
      fast_ovf    = sub_ovf;
    end
    if (op_en[OP_AND]) begin
      fast_result = data_operandA & data_operandB;
    end
    if (op_en[OP_OR]) begin
      fast_result = data_operandA | data_operandB;
    end
    if (op_en[OP_SLL]) begin
      fast_result = data_operandA << ctrl_shiftamt;
    end
    if (op_en[OP_SRA]) begin
      fast_result = sra_res;
    end
    if (op_en[OP_DIV] && b_zero) begin
      fast_exc = 1'b1;
    end
  end

  // Next-iteration values for the multiplier and divider.
  // Both datapaths work on magnitudes and apply the sign at the end.
  // The final iteration uses these combinational values directly, so the
  // result is registered on the same edge as the last step.
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_ovf;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_try;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   div_quot;

  always_comb begin
    mul_acc_next = mplier[0] ? (acc + mcand) : acc;
    mul_prod     = neg_q ? -mul_acc_next : mul_acc_next;
    // The product fits in WIDTH bits only if the upper half plus the result
    // sign bit are all equal.
    mul_ovf      = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || !(|mul_prod[2*WIDTH-1:WIDTH-1]));
    rem_shift    = {rem, quo[WIDTH-1]};
    rem_try      = rem_shift - {1'b0, divisor};
    // A borrow out of the trial subtraction means "restore".
    quo_next     = {quo[WIDTH-2:0], ~rem_try[WIDTH]};
    rem_next     = rem_try[WIDTH] ? rem_shift[WIDTH-1:0] : rem_try[WIDTH-1:0];
    div_quot     = neg_q ? -quo_next : quo_next;
  end

  // Control FSM and all registered outputs.
  // in_ready is a register that mirrors "state == IDLE".
  // It rises on the same edge that produces the final mul/div result, so a
  // new accept can overlap the out_valid cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      data_result <= '0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
      overflow    <= 1'b0;
      exception   <= 1'b0;
      neg_q       <= 1'b0;
      special_q   <= 1'b0;
      ne_q        <= 1'b0;
      lt_q        <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (start_iter) begin
              counter   <= '0;
              in_ready  <= 1'b0;
              ne_q      <= in_ne;
              lt_q      <= in_lt;
              neg_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
              special_q <= div_special;
              acc       <= '0;
              mcand     <= {{WIDTH{1'b0}}, abs_a};
              mplier    <= abs_b;
              rem       <= '0;
              quo       <= abs_a;
              divisor   <= abs_b;
              state     <= op_en[OP_MUL] ? MUL : DIV;
            end else begin
              out_valid   <= 1'b1;
              data_result <= fast_result;
              isNotEqual  <= fast_ne;
              isLessThan  <= fast_lt;
              overflow    <= fast_ovf;
              exception   <= fast_exc;
            end
          end
        end

        MUL: begin
          acc     <= mul_acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + 1'b1;
          if (counter == LAST_ITER) begin
            out_valid   <= 1'b1;
            data_result <= mul_prod[WIDTH-1:0];
            isNotEqual  <= ne_q;
            isLessThan  <= lt_q;
            overflow    <= mul_ovf;
            exception   <= mul_ovf;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end

        DIV: begin
          rem     <= rem_next;
          quo     <= quo_next;
          counter <= counter + 1'b1;
          if (counter == LAST_ITER) begin
            out_valid   <= 1'b1;
            // INT_MIN / -1 falls out of the magnitude divider as INT_MIN,
            // which is the wrapped result we want; only the flags need care.
            data_result <= div_quot;
            isNotEqual  <= ne_q;
            isLessThan  <= lt_q;
            overflow    <= special_q;
            exception   <= special_q;
            in_ready    <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed-vector bench for alu_exec_unit.
// Every expected value below was worked out by hand from the ALU's intended
// behaviour. Inputs are driven on the falling edge. Outputs are sampled 1 time
// unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        out_valid;
  logic [31:0] data_result;
  logic        isNotEqual;
  logic        isLessThan;
  logic        overflow;
  logic        exception;

  int vectorCount;
  int missCount;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .out_valid      (out_valid),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow),
    .exception      (exception)
  );

  // 10-unit clock period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single point of comparison: counts the vector and reports a miscompare.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation for exactly one accept edge.
  // Returns 1 time unit after that edge, in the first cycle after accept.
  task automatic applyStimulus(input logic [4:0] op, input logic [4:0] shamt,
                               input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    in_valid       = 1'b1;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = shamt;
    data_operandA  = a;
    data_operandB  = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Checks the result fields of the current cycle.
  task automatic expectResult(input string tag, input logic [31:0] res,
                              input logic ovf, input logic exc);
    checkOutput({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, ".result"}, {32'd0, data_result}, {32'd0, res});
    checkOutput({tag, ".overflow"}, {63'd0, overflow}, {63'd0, ovf});
    checkOutput({tag, ".exception"}, {63'd0, exception}, {63'd0, exc});
  endtask

  // Waits for out_valid after an iterative op, with a cycle bound.
  // It scrambles the operand inputs while busy; the latched copies must win.
  // cnt = 1 means the first cycle after the accept edge.
  task automatic waitIterative(input string tag);
    int cnt;
    int busy;
    cnt  = 1;
    busy = 0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
    while (!out_valid && cnt < 100) begin
      if (!in_ready) busy++;
      @(posedge clock);
      #1;
      cnt++;
    end
    checkOutput({tag, ".latency"}, 64'(cnt), 64'd33);
    checkOutput({tag, ".stall"}, 64'(busy), 64'd32);
    checkOutput({tag, ".readyAtDone"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int pulses;
    vectorCount    = 0;
    missCount      = 0;
    reset          = 1'b1;
    in_valid       = 1'b0;
    ctrl_ALUopcode = 5'd0;
    ctrl_shiftamt  = 5'd0;
    data_operandA  = 32'd0;
    data_operandB  = 32'd0;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset.result", {32'd0, data_result}, 64'd0);
    checkOutput("reset.ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset.flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);

    // add with signed overflow.
    applyStimulus(5'd0, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    expectResult("addOvf", 32'h8000_0000, 1'b1, 1'b0);
    checkOutput("addOvf.lt", {63'd0, isLessThan}, 64'd0);

    // Back-to-back sub then and.
    applyStimulus(5'd1, 5'd0, 32'd3, 32'd5);
    expectResult("sub", 32'hFFFF_FFFE, 1'b0, 1'b0);
    checkOutput("sub.lt", {63'd0, isLessThan}, 64'd1);
    checkOutput("sub.ne", {63'd0, isNotEqual}, 64'd1);
    applyStimulus(5'd2, 5'd0, 32'h0000_F0F0, 32'h0000_FF00);
    expectResult("and", 32'h0000_F000, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    checkOutput("and.pulseEnds", {63'd0, out_valid}, 64'd0);
    checkOutput("and.held", {32'd0, data_result}, 64'h0000_F000);

    // or, and isLessThan across a wrapping subtraction (INT_MIN - 1).
    applyStimulus(5'd3, 5'd0, 32'h0F0F_0000, 32'h0000_00FF);
    expectResult("or", 32'h0F0F_00FF, 1'b0, 1'b0);
    applyStimulus(5'd1, 5'd0, 32'h8000_0000, 32'h0000_0001);
    expectResult("subWrap", 32'h7FFF_FFFF, 1'b1, 1'b0);
    checkOutput("subWrap.lt", {63'd0, isLessThan}, 64'd1);

    // Shifts.
    applyStimulus(5'd5, 5'd4, 32'h8000_0000, 32'd0);
    expectResult("sra4", 32'hF800_0000, 1'b0, 1'b0);
    applyStimulus(5'd4, 5'd31, 32'h0000_0001, 32'd0);
    expectResult("sll31", 32'h8000_0000, 1'b0, 1'b0);
    applyStimulus(5'd4, 5'd0, 32'h1234_5678, 32'd0);
    expectResult("sll0", 32'h1234_5678, 1'b0, 1'b0);

    // Multiply.
    applyStimulus(5'd6, 5'd0, 32'hFFFF_FFF9, 32'd6);
    waitIterative("mulNeg");
    expectResult("mulNeg", 32'hFFFF_FFD6, 1'b0, 1'b0);
    applyStimulus(5'd6, 5'd0, 32'h0001_0000, 32'h0001_0000);
    waitIterative("mulOvf");
    expectResult("mulOvf", 32'h0000_0000, 1'b1, 1'b1);

    // Divide.
    applyStimulus(5'd7, 5'd0, 32'hFFFF_FFF9, 32'd2);
    waitIterative("divNeg");
    expectResult("divNeg", 32'hFFFF_FFFD, 1'b0, 1'b0);
    applyStimulus(5'd7, 5'd0, 32'd5, 32'd0);
    expectResult("divZero", 32'h0000_0000, 1'b0, 1'b1);
    checkOutput("divZero.ready", {63'd0, in_ready}, 64'd1);
    applyStimulus(5'd7, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIterative("divMin");
    expectResult("divMin", 32'h8000_0000, 1'b1, 1'b1);

    // Unknown opcode with equal operands.
    applyStimulus(5'd8, 5'd3, 32'd5, 32'd5);
    expectResult("badOp", 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("badOp.cmp", {62'd0, isNotEqual, isLessThan}, 64'd0);

    // Reset ten cycles into a multiply abandons it.
    applyStimulus(5'd6, 5'd0, 32'd3, 32'd4);
    pulses = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (out_valid) pulses++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abort.ready", {63'd0, in_ready}, 64'd1);
    repeat (40) begin
      if (out_valid) pulses++;
      @(posedge clock);
      #1;
    end
    checkOutput("abort.noPulse", 64'(pulses), 64'd0);
    applyStimulus(5'd0, 5'd0, 32'd2, 32'd2);
    expectResult("addAfterAbort", 32'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
